// File: rtl/sysid_version_check.sv
// Avalon-MM master that reads the system-ID slave (word 0 = ID, word 1 = timestamp),
// compares both words with build-time values and publishes a registered pass/fail summary.
module sysid_version_check #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout
);

    localparam logic [1:0]  LAT_LAST   = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam bit          LAT_ZERO   = (READ_LATENCY == 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_ID  = 3'd1,
        S_LAT_ID = 3'd2,
        S_RD_TS  = 3'd3,
        S_LAT_TS = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    function automatic logic id_differs(input logic [31:0] data);
        return data != EXPECTED_ID;
    endfunction

    function automatic logic ts_differs(input logic [31:0] data);
        return CHECK_TS && (data != EXPECTED_TS);
    endfunction

    state_t      r_state, w_state;
    logic [15:0] r_stall, w_stall;
    logic [1:0]  r_lat, w_lat;
    logic [31:0] r_id_value, w_id_value, r_ts_value, w_ts_value;
    logic        r_id_mismatch, w_id_mismatch, r_ts_mismatch, w_ts_mismatch;
    logic        r_timeout, w_timeout, r_done, w_done, r_match, w_match, r_busy, w_busy;

    // Next-state and next-result logic; reset parks in IDLE, which auto-launches when AUTO_START=1
    always_comb begin
        w_state       = r_state;
        w_stall       = r_stall;
        w_lat         = r_lat;
        w_id_value    = r_id_value;
        w_ts_value    = r_ts_value;
        w_id_mismatch = r_id_mismatch;
        w_ts_mismatch = r_ts_mismatch;
        w_timeout     = r_timeout;
        w_done        = r_done;
        w_match       = r_match;
        w_busy        = r_busy;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start || (AUTO_START && (r_state == S_IDLE))) begin
                    w_id_value    = 32'h0000_0000;
                    w_ts_value    = 32'h0000_0000;
                    w_id_mismatch = 1'b0;
                    w_ts_mismatch = 1'b0;
                    w_timeout     = 1'b0;
                    w_done        = 1'b0;
                    w_match       = 1'b0;
                    w_busy        = 1'b1;
                    w_stall       = 16'd0;
                    w_state       = S_RD_ID;
                end else begin
                    w_state = r_state;
                end
            end
            S_RD_ID, S_RD_TS: begin
                if (!avm_waitrequest) begin
                    if (!LAT_ZERO) begin
                        w_lat   = 2'd0;
                        w_state = (r_state == S_RD_ID) ? S_LAT_ID : S_LAT_TS;
                    end else if (r_state == S_RD_ID) begin
                        w_id_value    = avm_readdata;
                        w_id_mismatch = id_differs(avm_readdata);
                        w_stall       = 16'd0;
                        w_state       = S_RD_TS;
                    end else begin
                        w_ts_value    = avm_readdata;
                        w_ts_mismatch = ts_differs(avm_readdata);
                        w_match       = !r_id_mismatch && !ts_differs(avm_readdata);
                        w_done        = 1'b1;
                        w_busy        = 1'b0;
                        w_state       = S_DONE;
                    end
                end else if (r_stall == STALL_LAST) begin
                    w_timeout = 1'b1;
                    w_match   = 1'b0;
                    w_done    = 1'b1;
                    w_busy    = 1'b0;
                    w_state   = S_DONE;
                end else begin
                    w_stall = r_stall + 16'd1;
                end
            end
            S_LAT_ID: begin
                if (r_lat == LAT_LAST) begin
                    w_id_value    = avm_readdata;
                    w_id_mismatch = id_differs(avm_readdata);
                    w_stall       = 16'd0;
                    w_state       = S_RD_TS;
                end else begin
                    w_lat = r_lat + 2'd1;
                end
            end
            S_LAT_TS: begin
                if (r_lat == LAT_LAST) begin
                    w_ts_value    = avm_readdata;
                    w_ts_mismatch = ts_differs(avm_readdata);
                    w_match       = !r_id_mismatch && !ts_differs(avm_readdata);
                    w_done        = 1'b1;
                    w_busy        = 1'b0;
                    w_state       = S_DONE;
                end else begin
                    w_lat = r_lat + 2'd1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_stall       <= 16'd0;
            r_lat         <= 2'd0;
            r_id_value    <= 32'h0000_0000;
            r_ts_value    <= 32'h0000_0000;
            r_id_mismatch <= 1'b0;
            r_ts_mismatch <= 1'b0;
            r_timeout     <= 1'b0;
            r_done        <= 1'b0;
            r_match       <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_stall       <= w_stall;
            r_lat         <= w_lat;
            r_id_value    <= w_id_value;
            r_ts_value    <= w_ts_value;
            r_id_mismatch <= w_id_mismatch;
            r_ts_mismatch <= w_ts_mismatch;
            r_timeout     <= w_timeout;
            r_done        <= w_done;
            r_match       <= w_match;
            r_busy        <= w_busy;
        end
    end

    assign avm_read    = (r_state == S_RD_ID) || (r_state == S_RD_TS);
    assign avm_address = (r_state == S_RD_TS) || (r_state == S_LAT_TS);
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;
    assign id_mismatch = r_id_mismatch;
    assign ts_mismatch = r_ts_mismatch;
    assign timeout     = r_timeout;
    assign done        = r_done;
    assign match       = r_match;
    assign busy        = r_busy;

endmodule

// File: tb/tb_sysid_version_check.sv
// Directed bench: instance A (latency 0, timeout 4) and instance B (latency 2, timestamp unchecked).
module tb_sysid_version_check;

    logic        clock;
    logic        rst_a, start_a, wr_a, a_addr, a_read;
    logic [31:0] rd_a, a_id, a_ts, a_idv, a_tsv;
    logic        a_busy, a_done, a_match, a_idm, a_tsm, a_to;
    logic        rst_b, start_b, wr_b, b_addr, b_read;
    logic [31:0] rd_b, b_id, b_ts, b_idv, b_tsv;
    logic        b_busy, b_done, b_match, b_idm, b_tsm, b_to;
    logic        p1_v, p2_v, p1_a, p2_a;
    int          total = 0;
    int          bad = 0;

    sysid_version_check #(
        .EXPECTED_ID(32'h5A42_ABFE), .EXPECTED_TS(32'h0000_0000), .CHECK_TS(1'b1),
        .READ_LATENCY(0), .TIMEOUT_CYCLES(4), .AUTO_START(1'b1)
    ) u_a (
        .clock(clock), .reset(rst_a), .start(start_a),
        .avm_address(a_addr), .avm_read(a_read), .avm_waitrequest(wr_a), .avm_readdata(rd_a),
        .id_value(a_idv), .ts_value(a_tsv), .busy(a_busy), .done(a_done), .match(a_match),
        .id_mismatch(a_idm), .ts_mismatch(a_tsm), .timeout(a_to)
    );

    sysid_version_check #(
        .EXPECTED_ID(32'h5A42_ABFE), .EXPECTED_TS(32'h0000_0000), .CHECK_TS(1'b0),
        .READ_LATENCY(2), .TIMEOUT_CYCLES(255), .AUTO_START(1'b1)
    ) u_b (
        .clock(clock), .reset(rst_b), .start(start_b),
        .avm_address(b_addr), .avm_read(b_read), .avm_waitrequest(wr_b), .avm_readdata(rd_b),
        .id_value(b_idv), .ts_value(b_tsv), .busy(b_busy), .done(b_done), .match(b_match),
        .id_mismatch(b_idm), .ts_mismatch(b_tsm), .timeout(b_to)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Zero-latency slave for A; garbage outside a read so late capture is visible
    assign rd_a = a_read ? (a_addr ? a_ts : a_id) : 32'hDEAD_BEEF;

    // Two-cycle pipelined slave for B: data valid only in the second cycle after acceptance
    always @(posedge clock) begin
        if (rst_b) begin
            p1_v <= 1'b0; p2_v <= 1'b0; p1_a <= 1'b0; p2_a <= 1'b0;
        end else begin
            p1_v <= b_read && !wr_b;
            p1_a <= b_addr;
            p2_v <= p1_v;
            p2_a <= p1_a;
        end
    end
    assign rd_b = p2_v ? (p2_a ? b_ts : b_id) : 32'hDEAD_BEEF;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_a = 1'b1; start_a = 1'b0; wr_a = 1'b0; a_id = 32'h5A42_ABFE; a_ts = 32'h0000_0000;
        rst_b = 1'b1; start_b = 1'b0; wr_b = 1'b0; b_id = 32'h5A42_ABFE; b_ts = 32'hCAFE_0001;
        step(); step();
        chk1("rst_read", a_read, 1'b0);
        chk1("rst_busy", a_busy, 1'b0);
        chk1("rst_done", a_done, 1'b0);
        chk1("rst_match", a_match, 1'b0);
        chk1("rst_timeout", a_to, 1'b0);
        chk("rst_id", a_idv, 32'h0000_0000);

        // Auto-run, matching words, latency 0
        rst_a = 1'b0;
        step();
        chk1("c0_busy", a_busy, 1'b1);
        chk1("c0_read", a_read, 1'b1);
        chk1("c0_addr", a_addr, 1'b0);
        chk1("c0_done", a_done, 1'b0);
        step();
        chk1("c1_addr", a_addr, 1'b1);
        chk1("c1_read", a_read, 1'b1);
        chk("c1_id", a_idv, 32'h5A42_ABFE);
        chk1("c1_done", a_done, 1'b0);
        step();
        chk1("c2_done", a_done, 1'b1);
        chk1("c2_match", a_match, 1'b1);
        chk1("c2_busy", a_busy, 1'b0);
        chk1("c2_read", a_read, 1'b0);
        chk("c2_ts", a_tsv, 32'h0000_0000);

        // Rerun from DONE with a wrong ID
        a_id = 32'h5A42_ABFF;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk1("rerun_done_clr", a_done, 1'b0);
        chk1("rerun_busy", a_busy, 1'b1);
        chk("rerun_id_clr", a_idv, 32'h0000_0000);
        chk1("rerun_read", a_read, 1'b1);
        step();
        step();
        chk1("badid_done", a_done, 1'b1);
        chk1("badid_idm", a_idm, 1'b1);
        chk1("badid_tsm", a_tsm, 1'b0);
        chk1("badid_match", a_match, 1'b0);
        chk("badid_val", a_idv, 32'h5A42_ABFF);

        // Wrong timestamp; a start pulse while busy must be ignored
        a_id = 32'h5A42_ABFE;
        a_ts = 32'h1234_5678;
        start_a = 1'b1;
        step();
        chk1("busy_start_idm_clr", a_idm, 1'b0);
        step();
        start_a = 1'b0;
        chk1("busy_start_rdts", a_addr, 1'b1);
        step();
        chk1("badts_done", a_done, 1'b1);
        chk1("badts_tsm", a_tsm, 1'b1);
        chk1("badts_idm", a_idm, 1'b0);
        chk1("badts_match", a_match, 1'b0);
        step();
        chk1("noqueue_done", a_done, 1'b1);
        chk1("noqueue_busy", a_busy, 1'b0);

        // Waitrequest stuck high: timeout after 4 stall cycles
        a_ts = 32'h0000_0000;
        wr_a = 1'b1;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk1("to_s1_read", a_read, 1'b1);
        step(); step(); step();
        chk1("to_s4_done", a_done, 1'b0);
        chk1("to_s4_read", a_read, 1'b1);
        chk1("to_s4_addr", a_addr, 1'b0);
        step();
        chk1("to_done", a_done, 1'b1);
        chk1("to_flag", a_to, 1'b1);
        chk1("to_match", a_match, 1'b0);
        chk("to_id", a_idv, 32'h0000_0000);
        step();
        chk1("to_read_after", a_read, 1'b0);
        wr_a = 1'b0;

        // Reset during RD_TS aborts; fresh run completes
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk1("rst_mid_to_clr", a_to, 1'b0);
        step();
        chk1("rst_mid_rdts", a_addr, 1'b1);
        rst_a = 1'b1;
        step();
        chk1("abort_read", a_read, 1'b0);
        chk1("abort_busy", a_busy, 1'b0);
        chk("abort_id", a_idv, 32'h0000_0000);
        chk1("abort_done", a_done, 1'b0);
        rst_a = 1'b0;
        step();
        chk1("fresh_busy", a_busy, 1'b1);
        step(); step();
        chk1("fresh_done", a_done, 1'b1);
        chk1("fresh_match", a_match, 1'b1);

        // Instance B: latency 2, 3 stalls on the ID read, timestamp ignored
        wr_b = 1'b1;
        rst_b = 1'b0;
        step();
        chk1("b_c0_read", b_read, 1'b1);
        step(); step();
        chk1("b_c2_read", b_read, 1'b1);
        chk1("b_c2_addr", b_addr, 1'b0);
        step();
        wr_b = 1'b0;
        step();
        chk1("b_c4_read", b_read, 1'b0);
        chk1("b_c4_busy", b_busy, 1'b1);
        step(); step();
        chk1("b_c6_read", b_read, 1'b1);
        chk1("b_c6_addr", b_addr, 1'b1);
        chk("b_c6_id", b_idv, 32'h5A42_ABFE);
        step(); step();
        chk1("b_c8_done", b_done, 1'b0);
        step();
        chk1("b_c9_done", b_done, 1'b1);
        chk1("b_c9_match", b_match, 1'b1);
        chk1("b_c9_tsm", b_tsm, 1'b0);
        chk1("b_c9_to", b_to, 1'b0);
        chk("b_c9_ts", b_tsv, 32'hCAFE_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sysid_version_check.md
# sysid_version_check

Avalon-MM master that sequences reads of the Qsys system-ID slave (word 0 = system ID, word 1 = generation timestamp) after reset or on request. Compares both words against build-time expected values and publishes a registered pass/fail summary. Sits beside the sysid slave in the Qsys system and gates POV LED startup logic. Startup logic must not start the display until `done` is high and `match` is high.

## Interface
- `EXPECTED_ID`, 32'h0000_0000: expected value of word 0.
- `EXPECTED_TS`, 32'h0000_0000: expected value of word 1.
- `CHECK_TS`, 1: 1 = timestamp compared; 0 = timestamp read but `ts_mismatch` forced 0.
- `READ_LATENCY`, 0: fixed slave read latency in cycles, 0..3.
- `TIMEOUT_CYCLES`, 255: maximum consecutive `avm_waitrequest` cycles per read, 1..65535.
- `AUTO_START`, 1: 1 = check starts automatically after reset.

Ports:
- `clock` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request to rerun the check.
- `avm_address` out 1: word select, 0 = ID, 1 = timestamp.
- `avm_read` out 1: read strobe.
- `avm_waitrequest` in 1: slave stall. Tie to 0 for the sysid slave.
- `avm_readdata` in 32: read data.
- `id_value` out 32: captured word 0.
- `ts_value` out 32: captured word 1.
- `busy` out 1: check in progress.
- `done` out 1: check finished; results valid.
- `match` out 1: `done` and no mismatch and no timeout.
- `id_mismatch` out 1: captured ID differs from `EXPECTED_ID`.
- `ts_mismatch` out 1: captured timestamp differs from `EXPECTED_TS`. Always 0 when `CHECK_TS`=0.
- `timeout` out 1: a read exceeded `TIMEOUT_CYCLES`.

## Operation
- States:
  - IDLE: reached only when `AUTO_START`=0.
  - RD_ID.
  - LAT_ID.
  - RD_TS.
  - LAT_TS.
  - DONE.
- `avm_read`=1 only in RD_ID and RD_TS, decoded from the registered state.
- `avm_address`=0 in RD_ID/LAT_ID, 1 in RD_TS/LAT_TS, 0 elsewhere.
- A read is accepted in an RD_x cycle with `avm_waitrequest`=0. Address and read stay stable until acceptance.
- Data capture:
  - `READ_LATENCY`=0: `avm_readdata` captured on the acceptance edge, then RD_ID→RD_TS or RD_TS→DONE.
  - `READ_LATENCY`=N>0: acceptance moves RD_x→LAT_x. A latency counter runs for N cycles; data is captured on the edge ending the Nth cycle, then the next state is entered.
- `id_mismatch` is registered together with `id_value`; `ts_mismatch` together with `ts_value`.
- `done`, `match` and `busy`=0 are set on the edge that enters DONE.
- Timeout:
  - A stall counter clears on entry to each RD_x and increments each cycle with `avm_waitrequest`=1.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes to DONE with `timeout`=1, `match`=0.
  - Values not yet captured keep 0.
  - No timeout applies in LAT_x states.
- `start` handling:
  - Honoured only in IDLE or DONE.
  - Clears `done`, `match`, both mismatch flags, `timeout`, `id_value` and `ts_value`; sets `busy`; enters RD_ID on the next edge.
  - Ignored while `busy`=1. Not queued.
- `match` = ¬`id_mismatch` ∧ ¬`ts_mismatch` ∧ ¬`timeout`, valid only while `done`=1; otherwise 0.

## Timing
- Reset values: every output 0. FSM enters RD_ID (`AUTO_START`=1) or IDLE, so `busy`=1 from the first cycle after reset when `AUTO_START`=1.
- `reset` high on any edge aborts an in-progress check; no partial results are kept. `avm_read` drops in the cycle after that edge.
- Latency from reset release (`READ_LATENCY`=0, no stalls):
  - Cycle 0: RD_ID.
  - Cycle 1: RD_TS.
  - Cycle 2: `done`=1.
- General latency: 2 + 2·`READ_LATENCY` + total stall cycles from the first RD_ID cycle to `done`.
- `start` pulse in DONE at cycle t: `done`=0 and RD_ID at t+1; `done` again at t+3 (latency 0).
- Comparisons are full 32-bit equality; no masking.

## Test plan
- Auto-run, slave returning 32'h5A42_ABFE / 32'h0000_0000 with matching parameters, latency 0 → `done` and `match`=1 exactly 2 cycles after reset release; `id_value`=32'h5A42_ABFE.
- Wrong ID returned (32'h5A42_ABFF) → `id_mismatch`=1, `match`=0, `ts_mismatch`=0. Repeat with `CHECK_TS`=0 and a wrong timestamp → `ts_mismatch`=0, `match`=1.
- `READ_LATENCY`=2 plus 3 stall cycles on the ID read → `done` at cycle 9; captured values correct; address held stable through the stalls.
- `avm_waitrequest` stuck 1, `TIMEOUT_CYCLES`=4 → `timeout`=1, `match`=0, `done`=1 after 4 stall cycles; `avm_read`=0 thereafter.
- `start` pulsed while `busy` → ignored. `start` pulsed in DONE → flags cleared next cycle, new result 2 cycles later.
- `reset` asserted during RD_TS → all outputs 0 after the edge; a fresh check completes normally after release.
